// File: rtl/position_stepper.sv
// position_stepper
//   Advances one sprite's (x, y) position once per frame tick by a
//   fixed-point speed, in a one-hot direction. A turn request is buffered
//   until the maze reports that direction as legal. Horizontal motion
//   either wraps through a tunnel or clamps at the screen edges. Vertical
//   motion always clamps.
//
// Handshake: no valid/ready pairs. tick and load are single-cycle strobes
//   sampled on the rising clock edge. req_dir counts as a request only when
//   exactly one bit is set. legal_moves is a level input that is read on
//   every tick.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   tick                frame update strobe
//   load, load_x/y      force the position (respawn); takes priority over tick
//   req_dir             requested direction, one-hot {down, up, right, left}
//   legal_moves         legal directions at the current position, same order
//   speed               pixels per tick, FRAC_W fractional bits
//   xpos, ypos          registered position
//   cur_dir             direction being travelled (one-hot or 0)
//   moving              high while the internal state is MOVING
//   wrapped             one-cycle pulse when a tunnel wrap happens
module position_stepper #(
    parameter int COORD_W = 10,
    parameter int SPEED_W = 8,
    parameter int FRAC_W  = 4,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 639,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 479,
    parameter int X_START = 320,
    parameter int Y_START = 240,
    parameter int WRAP_X  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               load,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic [3:0]         req_dir,
    input  logic [3:0]         legal_moves,
    input  logic [SPEED_W-1:0] speed,
    output logic [COORD_W-1:0] xpos,
    output logic [COORD_W-1:0] ypos,
    output logic [3:0]         cur_dir,
    output logic               moving,
    output logic               wrapped
);

    typedef enum logic [1:0] {IDLE, MOVING, BLOCKED} state_t;

    localparam int STEP_W = SPEED_W + 1 - FRAC_W;
    // Two extra bits: one sign bit and one bit of headroom. The headroom
    // covers a position loaded out of range plus a full step.
    localparam int PW = COORD_W + 2;

    localparam logic signed [PW-1:0] X_LO   = PW'(X_MIN);
    localparam logic signed [PW-1:0] X_HI   = PW'(X_MAX);
    localparam logic signed [PW-1:0] Y_LO   = PW'(Y_MIN);
    localparam logic signed [PW-1:0] Y_HI   = PW'(Y_MAX);
    localparam logic signed [PW-1:0] X_SPAN = PW'(X_MAX - X_MIN + 1);

    state_t             state;
    logic [FRAC_W-1:0]  acc;
    logic [3:0]         pending;

    logic               req_valid;
    logic [3:0]         eff_pending;
    logic [3:0]         move_dir;
    logic               take_pending;
    logic [SPEED_W:0]   sum;
    logic [STEP_W-1:0]  step;
    logic signed [PW-1:0] step_s, x_cur, y_cur, x_next, y_next;
    logic               wrap_hit;

    // Exactly one bit set.
    assign req_valid = (req_dir != 4'd0) && ((req_dir & (req_dir - 4'd1)) == 4'd0);

    // moving is decoded directly from the state register.
    assign moving = (state == MOVING);

    always_comb begin
        eff_pending  = req_valid ? req_dir : pending;
        sum          = (SPEED_W+1)'(acc) + (SPEED_W+1)'(speed);
        step         = sum[SPEED_W:FRAC_W];
        step_s       = PW'(step);
        x_cur        = PW'(xpos);
        y_cur        = PW'(ypos);
        take_pending = 1'b0;
        move_dir     = 4'd0;
        wrap_hit     = 1'b0;

        // A legal pending turn beats continuing straight.
        if ((eff_pending & legal_moves) != 4'd0) begin
            move_dir     = eff_pending;
            take_pending = 1'b1;
        end else if ((cur_dir & legal_moves) != 4'd0) begin
            move_dir = cur_dir;
        end

        x_next = x_cur;
        y_next = y_cur;
        case (move_dir)
            4'b0001: begin
                x_next = x_cur - step_s;
                if (x_next < X_LO) begin
                    if (WRAP_X != 0) begin
                        x_next   = x_next + X_SPAN;
                        wrap_hit = 1'b1;
                    end else begin
                        x_next = X_LO;
                    end
                end else if (WRAP_X == 0 && x_next > X_HI) begin
                    x_next = X_HI;
                end
            end
            4'b0010: begin
                x_next = x_cur + step_s;
                if (x_next > X_HI) begin
                    if (WRAP_X != 0) begin
                        x_next   = x_next - X_SPAN;
                        wrap_hit = 1'b1;
                    end else begin
                        x_next = X_HI;
                    end
                end else if (WRAP_X == 0 && x_next < X_LO) begin
                    x_next = X_LO;
                end
            end
            4'b0100: begin
                y_next = y_cur - step_s;
                if (y_next < Y_LO)      y_next = Y_LO;
                else if (y_next > Y_HI) y_next = Y_HI;
            end
            4'b1000: begin
                y_next = y_cur + step_s;
                if (y_next > Y_HI)      y_next = Y_HI;
                else if (y_next < Y_LO) y_next = Y_LO;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xpos    <= COORD_W'(X_START);
            ypos    <= COORD_W'(Y_START);
            cur_dir <= 4'd0;
            pending <= 4'd0;
            acc     <= '0;
            wrapped <= 1'b0;
            state   <= IDLE;
        end else if (load) begin
            xpos    <= load_x;
            ypos    <= load_y;
            cur_dir <= 4'd0;
            pending <= 4'd0;
            acc     <= '0;
            wrapped <= 1'b0;
            state   <= IDLE;
        end else begin
            wrapped <= 1'b0;
            if (req_valid) pending <= req_dir;
            if (tick) begin
                if (move_dir != 4'd0) begin
                    acc     <= sum[FRAC_W-1:0];
                    xpos    <= COORD_W'(x_next);
                    ypos    <= COORD_W'(y_next);
                    wrapped <= wrap_hit;
                    state   <= MOVING;
                    if (take_pending) begin
                        cur_dir <= eff_pending;
                        pending <= 4'd0;
                    end
                end else begin
                    // Blocked: drop the sub-pixel remainder. A sprite that
                    // has never moved stays IDLE.
                    acc   <= '0;
                    state <= (cur_dir != 4'd0) ? BLOCKED : IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_position_stepper.sv
module tb_position_stepper;

    logic       clk = 1'b0;
    logic       rst, tick, load;
    logic [9:0] load_x, load_y;
    logic [3:0] req_dir, legal_moves;
    logic [7:0] speed;

    logic [9:0] w_x, w_y, c_x, c_y;
    logic [3:0] w_dir, c_dir;
    logic       w_mov, c_mov, w_wrp, c_wrp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    position_stepper #(.WRAP_X(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .load_x(load_x), .load_y(load_y), .req_dir(req_dir),
        .legal_moves(legal_moves), .speed(speed),
        .xpos(w_x), .ypos(w_y), .cur_dir(w_dir), .moving(w_mov), .wrapped(w_wrp)
    );

    position_stepper #(.WRAP_X(0)) dut_c (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .load_x(load_x), .load_y(load_y), .req_dir(req_dir),
        .legal_moves(legal_moves), .speed(speed),
        .xpos(c_x), .ypos(c_y), .cur_dir(c_dir), .moving(c_mov), .wrapped(c_wrp)
    );

    // Reference model: index 0 = wrap instance, 1 = clamp instance.
    // Directions are kept as indices (-1 = none). Speed is split into
    // whole pixels and a remainder in sixteenths.
    int mx[2], my[2], macc[2], mdir[2], mpend[2];
    bit mmov[2], mwrp[2];

    task automatic model_step(input int k, input bit wrap_mode);
        int r, eff, total, s, go;
        r = -1;
        if ($countones(req_dir) == 1)
            for (int i = 0; i < 4; i++) if (req_dir[i]) r = i;
        if (rst || load) begin
            mx[k]   = rst ? 320 : int'(load_x);
            my[k]   = rst ? 240 : int'(load_y);
            macc[k] = 0; mdir[k] = -1; mpend[k] = -1;
            mmov[k] = 0; mwrp[k] = 0;
        end else begin
            eff = (r >= 0) ? r : mpend[k];
            if (r >= 0) mpend[k] = r;
            mwrp[k] = 0;
            if (tick) begin
                total = macc[k] + int'(speed);
                s     = total / 16;
                go    = -1;
                if (eff >= 0 && legal_moves[eff]) begin
                    go = eff; mdir[k] = eff; mpend[k] = -1;
                end else if (mdir[k] >= 0 && legal_moves[mdir[k]]) begin
                    go = mdir[k];
                end
                if (go < 0) begin
                    macc[k] = 0;
                    mmov[k] = 0;
                end else begin
                    macc[k] = total % 16;
                    mmov[k] = 1;
                    case (go)
                        0: mx[k] -= s;
                        1: mx[k] += s;
                        2: my[k] -= s;
                        default: my[k] += s;
                    endcase
                    if (go < 2) begin
                        if (wrap_mode) begin
                            if (mx[k] < 0) begin mx[k] += 640; mwrp[k] = 1; end
                            else if (mx[k] > 639) begin mx[k] -= 640; mwrp[k] = 1; end
                        end else begin
                            if (mx[k] < 0) mx[k] = 0;
                            if (mx[k] > 639) mx[k] = 639;
                        end
                    end else begin
                        if (my[k] < 0) my[k] = 0;
                        if (my[k] > 479) my[k] = 479;
                    end
                end
            end
        end
    endtask

    function automatic logic [25:0] model_pack(input int k);
        logic [3:0] d;
        d = (mdir[k] < 0) ? 4'd0 : (4'd1 << mdir[k]);
        return {mx[k][9:0], my[k][9:0], d, mmov[k], mwrp[k]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, clock them in, advance the model, then
    // settle 1 ns past the edge before anything is sampled.
    task automatic drive(input bit r, input bit ld, input int lx, input int ly,
                         input logic [3:0] rq, input logic [3:0] lg,
                         input int spd, input bit tk);
        rst = r; load = ld; load_x = lx[9:0]; load_y = ly[9:0];
        req_dir = rq; legal_moves = lg; speed = spd[7:0]; tick = tk;
        @(posedge clk);
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        #1;
    endtask

    typedef struct {
        bit rst, load; int lx, ly; logic [3:0] req, legal; int spd; bit tick;
        int ex, ey; logic [3:0] ed; bit em, ew; int ecx;
    } vec_t;

    vec_t tbl[$];
    logic [25:0] exp_q[$];

    function automatic void add(bit r, bit ld, int lx, int ly, logic [3:0] rq,
                                logic [3:0] lg, int spd, bit tk, int ex, int ey,
                                logic [3:0] ed, bit em, bit ew, int ecx);
        vec_t v;
        v.rst = r; v.load = ld; v.lx = lx; v.ly = ly; v.req = rq; v.legal = lg;
        v.spd = spd; v.tick = tk; v.ex = ex; v.ey = ey; v.ed = ed; v.em = em;
        v.ew = ew; v.ecx = ecx;
        tbl.push_back(v);
    endfunction

    initial begin
        //  rst ld  lx  ly  req      legal    spd   tk  ex   ey   dir      mv ww cx
        add(1, 0,   0,  0, 4'b0000, 4'b0000, 0,    0, 320, 240, 4'b0000, 0, 0, 320); // reset
        add(0, 0,   0,  0, 4'b0000, 4'b1111, 8'h20,1, 320, 240, 4'b0000, 0, 0, 320); // no request
        add(0, 0,   0,  0, 4'b0001, 4'b1111, 8'h20,1, 318, 240, 4'b0001, 1, 0, 318); // left 2px
        add(0, 0,   0,  0, 4'b0000, 4'b1111, 8'h20,1, 316, 240, 4'b0001, 1, 0, 316);
        add(0, 1, 100,100, 4'b0000, 4'b1111, 0,    0, 100, 100, 4'b0000, 0, 0, 100); // load
        add(0, 0,   0,  0, 4'b0010, 4'b1111, 8'h18,1, 101, 100, 4'b0010, 1, 0, 101); // 1.5px
        add(0, 0,   0,  0, 4'b0000, 4'b1111, 8'h18,1, 103, 100, 4'b0010, 1, 0, 103);
        add(0, 0,   0,  0, 4'b0000, 4'b1111, 8'h18,1, 104, 100, 4'b0010, 1, 0, 104);
        add(0, 0,   0,  0, 4'b0000, 4'b1111, 8'h18,1, 106, 100, 4'b0010, 1, 0, 106);
        add(0, 0,   0,  0, 4'b0100, 4'b0011, 8'h10,1, 107, 100, 4'b0010, 1, 0, 107); // up held
        add(0, 0,   0,  0, 4'b0000, 4'b0011, 8'h10,0, 107, 100, 4'b0010, 1, 0, 107); // no tick
        add(0, 0,   0,  0, 4'b0000, 4'b0111, 8'h10,1, 107,  99, 4'b0100, 1, 0, 107); // turn up
        add(0, 0,   0,  0, 4'b0000, 4'b0000, 8'h10,1, 107,  99, 4'b0100, 0, 0, 107); // blocked
        add(0, 0,   0,  0, 4'b1000, 4'b0000, 8'h10,1, 107,  99, 4'b0100, 0, 0, 107); // still blocked
        add(0, 0,   0,  0, 4'b0000, 4'b1000, 8'h10,1, 107, 100, 4'b1000, 1, 0, 107); // resume down
        add(0, 1,   1, 50, 4'b0000, 4'b1111, 8'h20,1,   1,  50, 4'b0000, 0, 0,   1); // load beats tick
        add(0, 0,   0,  0, 4'b0001, 4'b1111, 8'h20,1, 639,  50, 4'b0001, 1, 1,   0); // wrap left
        add(0, 0,   0,  0, 4'b0000, 4'b1111, 8'h20,0, 639,  50, 4'b0001, 1, 0,   0); // pulse ends
        add(0, 1,  50, 60, 4'b0010, 4'b1111, 8'h20,1,  50,  60, 4'b0000, 0, 0,  50); // load+tick
        add(1, 1,  50, 60, 4'b0000, 4'b1111, 8'h20,1, 320, 240, 4'b0000, 0, 0, 320); // rst beats load
        add(0, 0,   0,  0, 4'b0010, 4'b1111, 8'h10,0, 320, 240, 4'b0000, 0, 0, 320); // pend right
        add(0, 0,   0,  0, 4'b0011, 4'b1111, 8'h10,1, 321, 240, 4'b0010, 1, 0, 321); // multi-bit ignored
        add(0, 0,   0,  0, 4'b0001, 4'b0010, 8'h10,1, 322, 240, 4'b0010, 1, 0, 322); // left not legal
        add(0, 0,   0,  0, 4'b0000, 4'b1111, 8'h10,1, 321, 240, 4'b0001, 1, 0, 321); // reversal
        add(0, 0,   0,  0, 4'b0000, 4'b1111, 0,    1, 321, 240, 4'b0001, 1, 0, 321); // step 0
        add(0, 1,  10,  2, 4'b0000, 4'b1111, 0,    0,  10,   2, 4'b0000, 0, 0,  10);
        add(0, 0,   0,  0, 4'b0100, 4'b1111, 8'h30,1,  10,   0, 4'b0100, 1, 0,  10); // y clamp
        add(0, 1, 638,  5, 4'b0000, 4'b1111, 0,    0, 638,   5, 4'b0000, 0, 0, 638);
        add(0, 0,   0,  0, 4'b0010, 4'b1111, 8'h30,1,   1,   5, 4'b0010, 1, 1, 639); // wrap right

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].load, tbl[i].lx, tbl[i].ly, tbl[i].req,
                  tbl[i].legal, tbl[i].spd, tbl[i].tick);
            check($sformatf("row%0d_x", i),    int'(w_x),   tbl[i].ex);
            check($sformatf("row%0d_y", i),    int'(w_y),   tbl[i].ey);
            check($sformatf("row%0d_dir", i),  int'(w_dir), int'(tbl[i].ed));
            check($sformatf("row%0d_mov", i),  int'(w_mov), int'(tbl[i].em));
            check($sformatf("row%0d_wrp", i),  int'(w_wrp), int'(tbl[i].ew));
            check($sformatf("row%0d_cx", i),   int'(c_x),   tbl[i].ecx);
            check($sformatf("row%0d_cwrp", i), int'(c_wrp), 0);
        end

        // Two consecutive left ticks from x=2 at 4px: wrap only on the first.
        drive(0, 1, 2, 2, 4'b0000, 4'b1111, 0, 0);
        drive(0, 0, 0, 0, 4'b0001, 4'b1111, 8'h40, 1);
        check("seq_wrap_x1", int'(w_x), 638);
        check("seq_wrap_p1", int'(w_wrp), 1);
        check("seq_clamp_x1", int'(c_x), 0);
        drive(0, 0, 0, 0, 4'b0000, 4'b1111, 8'h40, 1);
        check("seq_wrap_x2", int'(w_x), 634);
        check("seq_wrap_p2", int'(w_wrp), 0);
        check("seq_clamp_x2", int'(c_x), 0);
        check("seq_clamp_mov", int'(c_mov), 1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int sel;
            logic [3:0] rq;
            sel = $urandom_range(0, 9);
            if (sel <= 5)      rq = 4'd1 << $urandom_range(0, 3);
            else if (sel <= 7) rq = 4'd0;
            else               rq = 4'($urandom_range(0, 15));
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 639), $urandom_range(0, 479), rq,
                  4'($urandom_range(0, 15)), $urandom_range(0, 255),
                  $urandom_range(0, 1) == 1);
            exp_q.push_back(model_pack(0));
            exp_q.push_back(model_pack(1));
            begin
                logic [25:0] e;
                e = exp_q.pop_front();
                n_tests++;
                if ({w_x, w_y, w_dir, w_mov, w_wrp} != e) begin
                    n_fail++;
                    $display("FAIL rand_wrap cyc%0d: got %h expected %h", n,
                             {w_x, w_y, w_dir, w_mov, w_wrp}, e);
                end
                e = exp_q.pop_front();
                n_tests++;
                if ({c_x, c_y, c_dir, c_mov, c_wrp} != e) begin
                    n_fail++;
                    $display("FAIL rand_clamp cyc%0d: got %h expected %h", n,
                             {c_x, c_y, c_dir, c_mov, c_wrp}, e);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
